// File: rtl/costas_loop_filter.sv
// PI loop filter for the Costas carrier-recovery loop: phase error in, NCO phase increment out.
// Two-stage pipeline: stage 1 scales the error and updates the integrator, stage 2 sums and clamps.
module costas_loop_filter #(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      INT_WIDTH = 24,
   parameter int unsigned      KP_SHIFT  = 4,
   parameter int unsigned      KI_SHIFT  = 10,
   parameter logic [WIDTH-1:0] FREQ_INIT = 16'h4000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] error_tdata,
   input  logic             error_tvalid,
   input  logic             integ_clear,
   input  logic             integ_freeze,
   output logic [WIDTH-1:0] feedback_tdata,
   output logic             feedback_tvalid,
   output logic             integ_sat
);

   localparam int unsigned SW = INT_WIDTH + 2;
   localparam logic signed [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
   localparam logic signed [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0]     prop_q, prop_d;
   logic signed [INT_WIDTH-1:0] integ_q, integ_d;
   logic                        integ_sat_q, integ_sat_d;
   logic                        v1_q;
   logic signed [INT_WIDTH:0]   sum;
   logic signed [INT_WIDTH-1:0] integ_add;
   logic signed [INT_WIDTH-1:0] integ_sh;
   logic signed [SW-1:0]        s;
   logic [WIDTH-1:0]            fb_q, fb_d;
   logic                        fb_valid_q;

   // Stage 1: proportional term and saturating integrator
   always_comb begin
      sum = $signed({integ_q[INT_WIDTH-1], integ_q})
          + $signed({{(INT_WIDTH+1-WIDTH){error_tdata[WIDTH-1]}}, error_tdata});
      if (sum[INT_WIDTH] != sum[INT_WIDTH-1]) begin
         integ_add = sum[INT_WIDTH] ? INT_MIN : INT_MAX;
      end else begin
         integ_add = sum[INT_WIDTH-1:0];
      end

      prop_d      = prop_q;
      integ_d     = integ_q;
      integ_sat_d = integ_sat_q;
      if (error_tvalid) begin
         prop_d = $signed(error_tdata) >>> KP_SHIFT;
      end
      if (integ_clear) begin
         integ_d     = '0;
         integ_sat_d = 1'b0;
      end else if (!integ_freeze && error_tvalid) begin
         integ_d     = integ_add;
         integ_sat_d = (integ_add == INT_MAX) || (integ_add == INT_MIN);
      end
   end

   // Stage 2: nominal + P + I, clamped to the unsigned output range (never wraps)
   always_comb begin
      integ_sh = integ_q >>> KI_SHIFT;
      s = $signed({{(SW-WIDTH){1'b0}}, FREQ_INIT})
        + $signed({{(SW-WIDTH){prop_q[WIDTH-1]}}, prop_q})
        + $signed({{2{integ_sh[INT_WIDTH-1]}}, integ_sh});
      fb_d = fb_q;
      if (v1_q) begin
         if (s[SW-1]) begin
            fb_d = '0;
         end else if (|s[SW-2:WIDTH]) begin
            fb_d = '1;
         end else begin
            fb_d = s[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prop_q      <= '0;
         integ_q     <= '0;
         integ_sat_q <= 1'b0;
         v1_q        <= 1'b0;
         fb_q        <= FREQ_INIT;
         fb_valid_q  <= 1'b0;
      end else begin
         prop_q      <= prop_d;
         integ_q     <= integ_d;
         integ_sat_q <= integ_sat_d;
         v1_q        <= error_tvalid;
         fb_q        <= fb_d;
         fb_valid_q  <= v1_q;
      end
   end

   assign feedback_tdata  = fb_q;
   assign feedback_tvalid = fb_valid_q;
   assign integ_sat       = integ_sat_q;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Self-checking bench for costas_loop_filter: vector table plus scoreboard of expected outputs,
// with extra instances at the output rails for clamp behaviour.
module tb_costas_loop_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] error_tdata = '0;
   logic        error_tvalid = 1'b0;
   logic        integ_clear = 1'b0;
   logic        integ_freeze = 1'b0;
   logic [15:0] feedback_tdata, hi_tdata, lo_tdata;
   logic        feedback_tvalid, hi_tvalid, lo_tvalid;
   logic        integ_sat, hi_sat, lo_sat;

   int tests = 0;
   int fails = 0;
   logic [15:0] sb[$];
   logic [15:0] mon_exp;

   typedef struct {
      logic signed [15:0] e;
      logic               v;
      logic               c;
      logic               f;
      logic [15:0]        exp;
   } vec_t;
   vec_t vecs[15];

   always #5 clk = ~clk;

   costas_loop_filter dut (
      .clk(clk), .rst(rst), .error_tdata(error_tdata), .error_tvalid(error_tvalid),
      .integ_clear(integ_clear), .integ_freeze(integ_freeze),
      .feedback_tdata(feedback_tdata), .feedback_tvalid(feedback_tvalid), .integ_sat(integ_sat)
   );

   costas_loop_filter #(.FREQ_INIT(16'hFFF0)) dut_hi (
      .clk(clk), .rst(rst), .error_tdata(error_tdata), .error_tvalid(error_tvalid),
      .integ_clear(integ_clear), .integ_freeze(integ_freeze),
      .feedback_tdata(hi_tdata), .feedback_tvalid(hi_tvalid), .integ_sat(hi_sat)
   );

   costas_loop_filter #(.FREQ_INIT(16'h0010)) dut_lo (
      .clk(clk), .rst(rst), .error_tdata(error_tdata), .error_tvalid(error_tvalid),
      .integ_clear(integ_clear), .integ_freeze(integ_freeze),
      .feedback_tdata(lo_tdata), .feedback_tvalid(lo_tvalid), .integ_sat(lo_sat)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every valid output must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (feedback_tvalid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", {31'd0, feedback_tvalid}, 32'd0);
         end else begin
            mon_exp = sb.pop_front();
            check("feedback", {16'd0, feedback_tdata}, {16'd0, mon_exp});
         end
      end
   end

   // Called at posedge+1; drives one cycle of stimulus
   task automatic send(input logic signed [15:0] e, input logic v, input logic c,
                       input logic f, input logic [15:0] exp);
      error_tdata  = e;
      error_tvalid = v;
      integ_clear  = c;
      integ_freeze = f;
      if (v) sb.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      error_tvalid = 1'b0;
      integ_clear  = 1'b0;
      integ_freeze = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_outstanding", sb.size(), 32'd0);
      sb.delete();
   endtask

   // Called at posedge+1; asserts reset mid-cycle and checks it takes effect asynchronously
   task automatic do_reset(input bit chk);
      idle();
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      if (chk) begin
         check("rst_async_data", {16'd0, feedback_tdata}, 32'h4000);
         check("rst_async_valid", {31'd0, feedback_tvalid}, 32'd0);
         check("rst_async_sat", {31'd0, integ_sat}, 32'd0);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

   initial begin
      longint im;
      logic [15:0] ex;

      vecs[0]  = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4041};
      vecs[1]  = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4042};
      vecs[2]  = '{e: 16'sd0,     v: 0, c: 0, f: 0, exp: 16'h0000};
      vecs[3]  = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4043};
      vecs[4]  = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4044};
      vecs[5]  = '{e: 16'sd1024,  v: 1, c: 0, f: 1, exp: 16'h4044};
      vecs[6]  = '{e: 16'sd1024,  v: 1, c: 0, f: 1, exp: 16'h4044};
      vecs[7]  = '{e: 16'sd1024,  v: 1, c: 0, f: 1, exp: 16'h4044};
      vecs[8]  = '{e: 16'sd1024,  v: 1, c: 1, f: 1, exp: 16'h4040};
      vecs[9]  = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4041};
      vecs[10] = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4042};
      vecs[11] = '{e: 16'sd0,     v: 0, c: 1, f: 0, exp: 16'h0000};
      vecs[12] = '{e: 16'sd1024,  v: 1, c: 0, f: 0, exp: 16'h4041};
      vecs[13] = '{e: -16'sd1024, v: 1, c: 0, f: 0, exp: 16'h3FC0};
      vecs[14] = '{e: -16'sd1024, v: 1, c: 0, f: 0, exp: 16'h3FBF};

      // Power-on reset, then idle
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_data", {16'd0, feedback_tdata}, 32'h4000);
      check("reset_valid", {31'd0, feedback_tvalid}, 32'd0);
      check("reset_sat", {31'd0, integ_sat}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("idle_data", {16'd0, feedback_tdata}, 32'h4000);
      check("idle_valid", {31'd0, feedback_tvalid}, 32'd0);

      // Single sample and data hold
      send(16'sd160, 1, 0, 0, 16'h400A);
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("hold_data", {16'd0, feedback_tdata}, 32'h400A);

      // Async reset mid-cycle from a non-reset output value
      do_reset(1'b1);

      // Vector table: back-to-back, gap, freeze, clear+freeze, clear without valid
      foreach (vecs[i]) send(vecs[i].e, vecs[i].v, vecs[i].c, vecs[i].f, vecs[i].exp);
      drain();

      // Output clamp at both rails
      do_reset(1'b0);
      send(16'sd1024, 1, 0, 0, 16'h4041);
      drain();
      check("clamp_hi", {16'd0, hi_tdata}, 32'h0000FFFF);
      do_reset(1'b0);
      send(-16'sd1024, 1, 0, 0, 16'h3FBF);
      drain();
      check("clamp_lo", {16'd0, lo_tdata}, 32'h00000000);
      check("hi_negative_step", {16'd0, hi_tdata}, 32'h0000FFAF);

      // Integrator saturation
      do_reset(1'b0);
      im = 0;
      for (int i = 0; i < 256; i++) begin
         im = im + 32767;
         ex = 16'(16384 + 2047 + (im >>> 10));
         send(16'sd32767, 1, 0, 0, ex);
      end
      drain();
      check("sat_before_clip", {31'd0, integ_sat}, 32'd0);
      send(16'sd32767, 1, 0, 0, 16'h67FE);
      drain();
      check("sat_at_rail", {31'd0, integ_sat}, 32'd1);
      send(-16'sd1, 1, 0, 0, 16'h5FFE);
      drain();
      check("sat_released", {31'd0, integ_sat}, 32'd0);

      // Reset while samples are in flight: no stale valid, integrator restarts at zero
      do_reset(1'b0);
      send(16'sd1024, 1, 0, 0, 16'h4041);
      send(16'sd1024, 1, 0, 0, 16'h4042);
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) begin
         check("flush_no_valid", {31'd0, feedback_tvalid}, 32'd0);
         @(posedge clk);
         #1;
      end
      send(16'sd1024, 1, 0, 0, 16'h4041);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
